// File: rtl/pulse_gen_if.sv
// pulse_gen_if
// Configuration handshake bundle between the generator driver and pulse_gen.
//   cfg_valid   - driver offers a new configuration
//   cfg_ready   - pulse generator has a free pending slot
//   cfg_period  - period minus one, in clocks
//   cfg_duty    - duty fraction, cfg_duty / 2^DUTY_W
//   cfg_oneshot - 1 = stop after one period, 0 = run continuously
//   cfg_invert  - 1 = active output level is low
// master: the driver side; slave: the pulse generator side.
interface pulse_gen_if #(
  parameter int CNT_W  = 27,
  parameter int DUTY_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_period;
  logic [DUTY_W-1:0] cfg_duty;
  logic              cfg_oneshot;
  logic              cfg_invert;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    output cfg_oneshot,
    output cfg_invert,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    input  cfg_oneshot,
    input  cfg_invert,
    output cfg_ready
  );
endinterface

// File: rtl/pulse_gen.sv
// pulse_gen
// Programmable PWM / pulse generator. Produces a rectangular waveform on a
// multi-bit bus with runtime period, duty fraction and polarity, either
// continuously or as a single period. New configurations arrive through a
// valid/ready handshake, wait in a one-deep pending slot and are applied only
// in IDLE or on a period boundary, so the waveform never glitches mid-period.
// Ports:
//   clk_i        - clock
//   rst_i        - synchronous active-high reset
//   cfg          - configuration handshake (pulse_gen_if.slave)
//   start_i      - begin a run (only looked at in IDLE)
//   stop_i       - abort the run, return to IDLE (wins over start and wrap)
//   fnc_o        - registered waveform, all bits carry the same level
//   period_end_o - high during the last cycle of each period
//   done_o       - one-cycle pulse when a one-shot run completes
//   busy_o       - high while running
module pulse_gen #(
  parameter int CNT_W      = 27,
  parameter int DUTY_W     = 8,
  parameter int OUT_W      = 6,
  parameter int RST_PERIOD = 99
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pulse_gen_if.slave       cfg,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [OUT_W-1:0] fnc_o,
  output logic             period_end_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int PROD_W = CNT_W + 1 + DUTY_W;
  localparam logic [CNT_W-1:0]  RST_PER   = CNT_W'(RST_PERIOD);
  localparam logic [DUTY_W-1:0] HALF_DUTY = {1'b1, {(DUTY_W-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  // High-time threshold: ((per+1) * duty) >> DUTY_W. The product is widened
  // so per+1 = 2^CNT_W cannot overflow; the result always fits in CNT_W bits
  // because duty < 2^DUTY_W keeps it at or below per.
  function automatic logic [CNT_W-1:0] calcThr(input logic [CNT_W-1:0]  p,
                                               input logic [DUTY_W-1:0] d);
    logic [PROD_W-1:0] perPlusOne;
    logic [PROD_W-1:0] dutyExt;
    logic [PROD_W-1:0] prod;
    perPlusOne = PROD_W'(p) + PROD_W'(1);
    dutyExt    = PROD_W'(d);
    prod       = perPlusOne * dutyExt;
    return CNT_W'(prod >> DUTY_W);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;

  logic [CNT_W-1:0]  per_q, per_d;
  logic [CNT_W-1:0]  thr_q, thr_d;
  logic              oneshot_q, oneshot_d;
  logic              inv_q, inv_d;

  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  pendPer_q, pendPer_d;
  logic [DUTY_W-1:0] pendDuty_q, pendDuty_d;
  logic              pendOneshot_q, pendOneshot_d;
  logic              pendInv_q, pendInv_d;

  logic [OUT_W-1:0]  fnc_q, fnc_d;
  logic              periodEnd_q, periodEnd_d;
  logic              done_q, done_d;

  logic              applyPend;
  logic              accept;

  // FSM and period counter. IDLE holds the counter at zero and folds any
  // pending configuration into the active set straight away. In RUN the
  // counter wraps at per; the wrap is the only place a pending configuration
  // may take over, and a one-shot run ends there with a done pulse. stop
  // overrides everything and deliberately produces no done pulse.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    applyPend = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        applyPend = pend_q;
        if (start_i && !stop_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d   = IDLE;
          counter_d = '0;
        end else if (counter_q == per_q) begin
          counter_d = '0;
          applyPend = pend_q;
          if (oneshot_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Configuration path. The slot only accepts while empty, and it can only be
  // applied while full, so capture and apply never collide on one edge; a
  // config captured on a wrap therefore waits for the following wrap. The
  // threshold is derived from the latched pending values, never the live bus.
  // The output is computed from the next-state counter and next active config
  // so the registered fnc lines up with the counter it describes.
  always_comb begin
    accept        = cfg.cfg_valid && !pend_q;

    pendPer_d     = pendPer_q;
    pendDuty_d    = pendDuty_q;
    pendOneshot_d = pendOneshot_q;
    pendInv_d     = pendInv_q;
    pend_d        = pend_q;
    if (accept) begin
      pendPer_d     = cfg.cfg_period;
      pendDuty_d    = cfg.cfg_duty;
      pendOneshot_d = cfg.cfg_oneshot;
      pendInv_d     = cfg.cfg_invert;
      pend_d        = 1'b1;
    end else if (applyPend) begin
      pend_d        = 1'b0;
    end

    per_d     = per_q;
    thr_d     = thr_q;
    oneshot_d = oneshot_q;
    inv_d     = inv_q;
    if (applyPend) begin
      per_d     = pendPer_q;
      thr_d     = calcThr(pendPer_q, pendDuty_q);
      oneshot_d = pendOneshot_q;
      inv_d     = pendInv_q;
    end

    if ((state_d == RUN) && (counter_d < thr_d)) begin
      fnc_d = {OUT_W{~inv_d}};
    end else begin
      fnc_d = {OUT_W{inv_d}};
    end
    periodEnd_d = (state_d == RUN) && (counter_d == per_d);
  end

  // State register. Reset also empties the pending slot and restores the
  // default 50% waveform on RST_PERIOD+1 clocks.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      per_q         <= RST_PER;
      thr_q         <= calcThr(RST_PER, HALF_DUTY);
      oneshot_q     <= 1'b0;
      inv_q         <= 1'b0;
      pend_q        <= 1'b0;
      pendPer_q     <= '0;
      pendDuty_q    <= '0;
      pendOneshot_q <= 1'b0;
      pendInv_q     <= 1'b0;
      fnc_q         <= '0;
      periodEnd_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      per_q         <= per_d;
      thr_q         <= thr_d;
      oneshot_q     <= oneshot_d;
      inv_q         <= inv_d;
      pend_q        <= pend_d;
      pendPer_q     <= pendPer_d;
      pendDuty_q    <= pendDuty_d;
      pendOneshot_q <= pendOneshot_d;
      pendInv_q     <= pendInv_d;
      fnc_q         <= fnc_d;
      periodEnd_q   <= periodEnd_d;
      done_q        <= done_d;
    end
  end

  assign cfg.cfg_ready = !pend_q;
  assign fnc_o         = fnc_q;
  assign period_end_o  = periodEnd_q;
  assign done_o        = done_q;
  assign busy_o        = (state_q == RUN);

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen
// Directed bench for pulse_gen: continuous 50%, mid-run reconfiguration with
// inversion, stop, start+stop in IDLE, one-shot, duty 0, period 0 and reset
// with a pending config followed by the reset-default waveform.
module tb_pulse_gen;

  localparam int CNT_W  = 27;
  localparam int DUTY_W = 8;
  localparam int OUT_W  = 6;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [OUT_W-1:0] fnc;
  logic             periodEnd;
  logic             done;
  logic             busy;

  int errors = 0;
  int checks = 0;

  pulse_gen_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) cfgIf ();

  pulse_gen #(
    .CNT_W(CNT_W), .DUTY_W(DUTY_W), .OUT_W(OUT_W), .RST_PERIOD(99)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg(cfgIf.slave),
    .start_i(start), .stop_i(stop),
    .fnc_o(fnc), .period_end_o(periodEnd), .done_o(done), .busy_o(busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before looking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive every input of the block in one place.
  task automatic applyStimulus(input logic r, input logic st, input logic sp,
                               input logic v, input int per, input int duty,
                               input logic os, input logic inv);
    rst                = r;
    start              = st;
    stop               = sp;
    cfgIf.cfg_valid    = v;
    cfgIf.cfg_period   = CNT_W'(per);
    cfgIf.cfg_duty     = DUTY_W'(duty);
    cfgIf.cfg_oneshot  = os;
    cfgIf.cfg_invert   = inv;
  endtask

  // Compare all outputs against hand-derived values.
  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] expFnc,
                             input logic expPe, input logic expDone,
                             input logic expBusy, input logic expReady);
    checks++;
    assert (fnc === expFnc) else begin
      errors++;
      $error("[TB] FAIL %s fnc observed=%h expected=%h", tag, fnc, expFnc);
    end
    checks++;
    assert (periodEnd === expPe) else begin
      errors++;
      $error("[TB] FAIL %s period_end observed=%b expected=%b", tag, periodEnd, expPe);
    end
    checks++;
    assert (done === expDone) else begin
      errors++;
      $error("[TB] FAIL %s done observed=%b expected=%b", tag, done, expDone);
    end
    checks++;
    assert (busy === expBusy) else begin
      errors++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
    end
    checks++;
    assert (cfgIf.cfg_ready === expReady) else begin
      errors++;
      $error("[TB] FAIL %s cfg_ready observed=%b expected=%b", tag, cfgIf.cfg_ready, expReady);
    end
  endtask

  initial begin
    // Reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    checkOutput("reset", 6'h00, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("idle_after_reset", 6'h00, 0, 0, 0, 1);

    // Continuous period=9 duty=128 -> thr=5; start on the apply edge
    applyStimulus(0, 0, 0, 1, 9, 128, 0, 0);
    step();
    checkOutput("cfg1_pending", 6'h00, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("cont50_c%0d", i % 10), (i % 10 < 5) ? 6'h3F : 6'h00,
                  (i % 10 == 9), 0, 1, 1);
      step();
    end

    // Counter is 0 again; offer period=4 duty=128 invert while running
    applyStimulus(0, 0, 0, 1, 4, 128, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("midrun_old_c%0d", c), (c < 5) ? 6'h3F : 6'h00,
                  (c == 9), 0, 1, 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("midrun_new_c%0d", i % 5), (i % 5 < 2) ? 6'h00 : 6'h3F,
                  (i % 5 == 4), 0, 1, 1);
      step();
    end

    // Stop at counter=3 (inverted config: inactive level is 3F)
    step();
    step();
    step();
    checkOutput("before_stop_c3", 6'h3F, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    checkOutput("after_stop", 6'h3F, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("after_stop_nodone", 6'h3F, 0, 0, 0, 1);

    // start and stop together in IDLE stay in IDLE
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    step();
    checkOutput("start_stop_idle", 6'h3F, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // One-shot period=3 duty=64 -> thr=1
    applyStimulus(0, 0, 0, 1, 3, 64, 1, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oneshot_c0", 6'h3F, 0, 0, 1, 1);
    step();
    checkOutput("oneshot_c1", 6'h00, 0, 0, 1, 1);
    step();
    checkOutput("oneshot_c2", 6'h00, 0, 0, 1, 1);
    step();
    checkOutput("oneshot_c3", 6'h00, 1, 0, 1, 1);
    step();
    checkOutput("oneshot_done", 6'h00, 0, 1, 0, 1);
    step();
    checkOutput("oneshot_after1", 6'h00, 0, 0, 0, 1);
    step();
    checkOutput("oneshot_after2", 6'h00, 0, 0, 0, 1);

    // duty=0, period=3 continuous -> never active
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("duty0_c%0d", i % 4), 6'h00, (i % 4 == 3), 0, 1, 1);
      step();
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("duty0_stopped", 6'h00, 0, 0, 0, 1);

    // period=0 duty=128 -> thr=0, period_end every cycle
    applyStimulus(0, 0, 0, 1, 0, 128, 0, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("per0_%0d", i), 6'h00, 1, 0, 1, 1);
      step();
    end

    // Reset mid-run with a config pending
    applyStimulus(0, 0, 0, 1, 9, 200, 1, 1);
    step();
    checkOutput("pend_before_rst", 6'h00, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("rst_midrun", 6'h00, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 110; i++) begin
      checkOutput($sformatf("default_c%0d", i % 100), (i % 100 < 50) ? 6'h3F : 6'h00,
                  (i % 100 == 99), 0, 1, 1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Parametrised PWM/pulse generator, successor to the fixed-duty square-wave block in the function-generator datapath. Produces a rectangular waveform on a multi-bit `fnc` bus with a runtime-programmable period, duty fraction and polarity, in continuous or one-shot mode. New configurations are accepted through a valid/ready handshake and applied glitch-free on period boundaries. Sits between the generator driver, which supplies configuration and start/stop, and the output DAC mux.

## Interface
- `CNT_W`, 27: period counter width; the period is `cfg_period+1` clocks, max 2^CNT_W.
- `DUTY_W`, 8: duty fraction width; duty = `cfg_duty`/2^DUTY_W.
- `OUT_W`, 6: output bus width; all bits carry the same level.
- `RST_PERIOD`, 99: active period loaded at reset.

- `clk` in 1: clock.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration slot free.
- `cfg_period` in CNT_W: period minus one.
- `cfg_duty` in DUTY_W: duty fraction.
- `cfg_oneshot` in 1: 1 = one-shot, 0 = continuous.
- `cfg_invert` in 1: 1 = active level low.
- `start` in 1: begin running, sampled in IDLE only.
- `stop` in 1: abort the run and go to IDLE.
- `fnc` out OUT_W: waveform output, registered.
- `period_end` out 1: high during the last cycle of each period.
- `done` out 1: one-cycle pulse when a one-shot completes.
- `busy` out 1: high in RUN.

## Operation
- Active config registers: `per`, `thr`, `oneshot`, `inv`. Pending config registers are accompanied by a `pend` flag.
- `thr = ((per+1) * duty) >> DUTY_W`.
  - The product is CNT_W+1+DUTY_W bits wide.
  - The result is truncated to CNT_W bits. It is lossless because `thr <= per`.
  - `thr` is computed from pending values when they are applied, never recomputed from live inputs.
- Handshake:
  - `cfg_ready = !pend`.
  - On `cfg_valid && cfg_ready` the config is captured into pending and `pend <= 1`.
  - A second config cannot be captured while one is pending.
- FSM states: IDLE and RUN.
- IDLE:
  - `counter = 0`.
  - `fnc = {OUT_W{inv}}` (the inactive level).
  - If `pend`, pending is applied to active at the next edge and `pend` clears.
  - If `start && !stop`, the FSM goes to RUN with `counter <= 0`. If `pend` is set on that same edge, the run uses the pending config.
- RUN:
  - `counter` increments each cycle.
  - When `counter == per`, this is the wrap edge: `counter <= 0`.
  - At the wrap edge, if `pend`, the pending config is applied, so the next period uses it.
  - Also at the wrap edge, if `oneshot` (the active value for the period that just ended), the FSM goes to IDLE and `done <= 1` for one cycle.
- `stop` in RUN:
  - Next state is IDLE, `counter <= 0`, `fnc` goes inactive.
  - No `done` pulse.
  - Pending config is kept and applied in IDLE.
- `stop` has priority over `start` and over the wrap.
- A config accepted on a wrap edge is applied at the following wrap, not the current one.
- Output:
  - `fnc` is registered from the next-state counter, so it is aligned with `counter`.
  - Active level `{OUT_W{~inv}}` while RUN and `counter < thr`.
  - Inactive level otherwise.
- Boundaries:
  - `duty = 0` gives `thr = 0`: the output is never active.
  - 100% duty is unreachable; the maximum is `(2^DUTY_W-1)/2^DUTY_W`.
  - `per = 0` gives a 1-clock period and `thr = 0`.

## Timing
- Reset values:
  - `counter = 0`, state IDLE.
  - `per = RST_PERIOD`, `thr` computed for duty 2^(DUTY_W-1) (50%).
  - `oneshot = 0`, `inv = 0`, `pend = 0`.
  - `fnc = 0`, `period_end = 0`, `done = 0`, `busy = 0`, `cfg_ready = 1`.
- Reset mid-run returns all of the above on the next edge, and the pending config is discarded.
- `start` sampled at edge k:
  - After edge k, `busy = 1`, `counter = 0`, and `fnc` is active if `thr > 0`.
  - `fnc` is active for `thr` cycles, then inactive for `per+1-thr` cycles.
- `period_end` is registered and high while `counter == per` in RUN.
- After a one-shot wrap edge, `done = 1` and `busy = 0` in the same cycle.
- `cfg_ready` rises the cycle after the pending config is applied.

## Test plan
- Reset, then `cfg` period=9 duty=128 continuous, then `start`:
  - `fnc = 6'h3F` for 5 cycles and `6'h00` for 5 cycles, repeating.
  - `period_end` every 10th cycle.
- One-shot, period=3 duty=64 (`thr = 1`):
  - One cycle of `6'h3F`, then 3 cycles of `6'h00`.
  - `done` pulses once with `busy` low, then the output stays at `6'h00`.
- Mid-run, config period=4 duty=128 invert=1 while running period=9:
  - `cfg_ready` stays low until the wrap.
  - The next period is 5 cycles: `6'h00` for 2 cycles, `6'h3F` for 3 cycles.
- `stop` at counter=3:
  - Next cycle `busy = 0`, `fnc` is at the inactive level, and no `done` pulse.
  - `start` and `stop` asserted together in IDLE: the FSM remains in IDLE.
- duty=0 gives constant `6'h00`. period=0 gives `period_end` high every cycle.
- `rst` mid-run with a config pending:
  - All outputs return to their reset values and `cfg_ready = 1`.
  - `start` then produces the 100-clock, 50% waveform from the `RST_PERIOD` default.
